// File: rtl/cache_line_fill.sv
// cache_line_fill: memory-side line bridge for the set-associative cache.
// On fill_req it writes the dirty victim line back (if wb_req) and then fetches
// the missing line one MEM_WIDTH beat at a time. The assembled line is presented
// on fill_data with a one-cycle fill_valid pulse. A per-beat timer aborts the
// transaction with a one-cycle err pulse if memory stops acknowledging.
//
// Ports:
//   clk, rst             clock (rising edge), asynchronous active-high reset
//   fill_req, wb_req     start request; wb_req is sampled only together with fill_req
//   fill_addr, wb_addr   miss / victim byte addresses (line offset bits ignored)
//   wb_data              victim line contents
//   busy                 transaction in progress
//   fill_data, fill_valid  assembled line and its completion pulse
//   err                  timeout pulse, transaction aborted
//   mem_req, mem_we, mem_addr, mem_wdata  beat request to memory
//   mem_ack, mem_rdata   beat completion and read data from memory
module cache_line_fill #(
  parameter int unsigned LINE_BITS  = 512,
  parameter int unsigned MEM_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fill_req,
  input  logic                  wb_req,
  input  logic [ADDR_WIDTH-1:0] fill_addr,
  input  logic [ADDR_WIDTH-1:0] wb_addr,
  input  logic [LINE_BITS-1:0]  wb_data,
  output logic                  busy,
  output logic [LINE_BITS-1:0]  fill_data,
  output logic                  fill_valid,
  output logic                  err,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [MEM_WIDTH-1:0]  mem_wdata,
  input  logic                  mem_ack,
  input  logic [MEM_WIDTH-1:0]  mem_rdata
);

  localparam int unsigned BEATS  = LINE_BITS / MEM_WIDTH;
  localparam int unsigned OFF    = $clog2(LINE_BITS / 8);
  localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  localparam logic [BEAT_W-1:0]     LAST_BEAT  = BEAT_W'(BEATS - 1);
  localparam logic [ADDR_WIDTH-1:0] BEAT_BYTES = ADDR_WIDTH'(MEM_WIDTH / 8);
  localparam logic [15:0]           TIMEOUT_V  = 16'(TIMEOUT);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WB   = 2'd1;
  localparam logic [1:0] ST_FILL = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [BEAT_W-1:0]     beat_q, beat_d;
  logic [15:0]           timer_q, timer_d;
  logic [ADDR_WIDTH-1:0] fill_base_q, fill_base_d;
  logic [ADDR_WIDTH-1:0] wb_base_q, wb_base_d;
  logic [LINE_BITS-1:0]  wb_data_q, wb_data_d;
  logic [LINE_BITS-1:0]  fill_data_q, fill_data_d;
  logic                  busy_q, busy_d;
  logic                  fill_valid_q, fill_valid_d;
  logic                  err_q, err_d;
  logic                  mem_req_q, mem_req_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [MEM_WIDTH-1:0]  mem_wdata_q, mem_wdata_d;

  logic [BEAT_W-1:0]     beat_inc;
  logic [31:0]           lsb_cur;
  logic [31:0]           lsb_nxt;
  logic [ADDR_WIDTH-1:0] off_nxt;

  assign beat_inc = beat_q + BEAT_W'(1);
  assign lsb_cur  = MEM_WIDTH * 32'(beat_q);
  assign lsb_nxt  = MEM_WIDTH * 32'(beat_inc);
  assign off_nxt  = ADDR_WIDTH'(beat_inc) * BEAT_BYTES;

  // The beat address/data for the *next* beat is computed here so that every
  // memory-side output is a plain register and stays stable until acked.
  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    timer_d      = timer_q;
    fill_base_d  = fill_base_q;
    wb_base_d    = wb_base_q;
    wb_data_d    = wb_data_q;
    fill_data_d  = fill_data_q;
    busy_d       = busy_q;
    fill_valid_d = 1'b0;
    err_d        = 1'b0;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;

    unique case (state_q)
      ST_IDLE: begin
        if (fill_req) begin
          fill_base_d = {fill_addr[ADDR_WIDTH-1:OFF], {OFF{1'b0}}};
          wb_base_d   = {wb_addr[ADDR_WIDTH-1:OFF], {OFF{1'b0}}};
          wb_data_d   = wb_data;
          beat_d      = '0;
          timer_d     = '0;
          busy_d      = 1'b1;
          mem_req_d   = 1'b1;
          if (wb_req) begin
            state_d     = ST_WB;
            mem_we_d    = 1'b1;
            mem_addr_d  = wb_base_d;
            mem_wdata_d = wb_data[MEM_WIDTH-1:0];
          end else begin
            state_d    = ST_FILL;
            mem_we_d   = 1'b0;
            mem_addr_d = fill_base_d;
          end
        end
      end

      ST_WB, ST_FILL: begin
        if (mem_ack) begin
          timer_d = '0;
          if (state_q == ST_FILL) begin
            fill_data_d[lsb_cur +: MEM_WIDTH] = mem_rdata;
          end
          if (beat_q == LAST_BEAT) begin
            beat_d = '0;
            if (state_q == ST_WB) begin
              // mem_req stays high straight into the read phase
              state_d    = ST_FILL;
              mem_we_d   = 1'b0;
              mem_addr_d = fill_base_q;
            end else begin
              state_d      = ST_DONE;
              mem_req_d    = 1'b0;
              fill_valid_d = 1'b1;
            end
          end else begin
            beat_d = beat_inc;
            if (state_q == ST_WB) begin
              mem_addr_d  = wb_base_q + off_nxt;
              mem_wdata_d = wb_data_q[lsb_nxt +: MEM_WIDTH];
            end else begin
              mem_addr_d = fill_base_q + off_nxt;
            end
          end
        end else if (timer_q == TIMEOUT_V) begin
          // Abort; fill_data keeps whatever beats already landed.
          state_d   = ST_IDLE;
          err_d     = 1'b1;
          busy_d    = 1'b0;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      beat_q       <= '0;
      timer_q      <= '0;
      fill_base_q  <= '0;
      wb_base_q    <= '0;
      wb_data_q    <= '0;
      fill_data_q  <= '0;
      busy_q       <= 1'b0;
      fill_valid_q <= 1'b0;
      err_q        <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      timer_q      <= timer_d;
      fill_base_q  <= fill_base_d;
      wb_base_q    <= wb_base_d;
      wb_data_q    <= wb_data_d;
      fill_data_q  <= fill_data_d;
      busy_q       <= busy_d;
      fill_valid_q <= fill_valid_d;
      err_q        <= err_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  assign busy       = busy_q;
  assign fill_data  = fill_data_q;
  assign fill_valid = fill_valid_q;
  assign err        = err_q;
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;

endmodule
